// File: rtl/spsram_bist_128x50.sv
// March C- BIST controller for a 128x50 single-port SRAM with byte-group write enables.
// Issues one SRAM access per cycle and checks each read one cycle after the SRAM returns its data.
module spsram_bist_128x50 #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 50,
  parameter int WE_WIDTH   = 5,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  bist_start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic                  mem_cen,
  output logic [WE_WIDTH-1:0]   mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_d,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  // state | meaning
  // IDLE  | waiting for bist_start after reset
  // M0    | up w0
  // M1    | up (r0,w1)
  // M2    | up (r1,w0)
  // M3    | down (r0,w1)
  // M4    | down (r1,w0)
  // M5    | up r0
  // DRAIN | no access; last read compared at exit
  // DONE  | result held; bist_start restarts
  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, nxt_state;
  logic [ADDR_WIDTH-1:0] addr, nxt_addr, last_addr;
  logic                  ph, nxt_ph;
  logic                  nxt_act, nxt_wr, nxt_bg;
  logic                  op_bg;
  logic [2:0]            op_elem;
  logic                  rd_vld, rd_bg;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [2:0]            rd_elem;

  function automatic logic is_down(input state_t s);
    return (s == M3) || (s == M4);
  endfunction

  function automatic logic is_two(input state_t s);
    return (s == M1) || (s == M2) || (s == M3) || (s == M4);
  endfunction

  function automatic logic [2:0] elem_of(input state_t s);
    case (s)
      M1:      return 3'd1;
      M2:      return 3'd2;
      M3:      return 3'd3;
      M4:      return 3'd4;
      M5:      return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Next access is computed here and registered, so the SRAM pins carry op k between E(k) and E(k+1).
  always_comb begin
    nxt_state = state;
    nxt_addr  = addr;
    nxt_ph    = 1'b0;
    nxt_act   = 1'b0;
    last_addr = is_down(state) ? '0 : ADDR_LAST;
    case (state)
      IDLE, DONE: begin
        if (bist_start) begin
          nxt_state = M0;
          nxt_addr  = '0;
          nxt_act   = 1'b1;
        end
      end
      M0, M1, M2, M3, M4, M5: begin
        nxt_act = 1'b1;
        if (is_two(state) && !ph) begin
          nxt_ph = 1'b1;
        end else if (addr != last_addr) begin
          nxt_addr = is_down(state) ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end else begin
          case (state)
            M0:      begin nxt_state = M1; nxt_addr = '0;        end
            M1:      begin nxt_state = M2; nxt_addr = '0;        end
            M2:      begin nxt_state = M3; nxt_addr = ADDR_LAST; end
            M3:      begin nxt_state = M4; nxt_addr = ADDR_LAST; end
            M4:      begin nxt_state = M5; nxt_addr = '0;        end
            default: begin nxt_state = DRAIN; nxt_addr = '0; nxt_act = 1'b0; end
          endcase
        end
      end
      DRAIN:   nxt_state = DONE;
      default: nxt_state = IDLE;
    endcase
    nxt_wr = (nxt_state == M0) || nxt_ph;
    nxt_bg = nxt_wr ? ((nxt_state == M1) || (nxt_state == M3))
                    : ((nxt_state == M2) || (nxt_state == M4));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      addr      <= '0;
      ph        <= 1'b0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      mem_cen   <= 1'b1;
      mem_wen   <= '1;
      mem_a     <= '0;
      mem_d     <= '0;
      op_bg     <= 1'b0;
      op_elem   <= '0;
      rd_vld    <= 1'b0;
      rd_bg     <= 1'b0;
      rd_addr   <= '0;
      rd_elem   <= '0;
    end else begin
      state   <= nxt_state;
      addr    <= nxt_addr;
      ph      <= nxt_ph;
      mem_cen <= !nxt_act;
      mem_wen <= {WE_WIDTH{!(nxt_act && nxt_wr)}};
      mem_a   <= nxt_act ? nxt_addr : '0;
      mem_d   <= {DATA_WIDTH{nxt_act && nxt_wr && nxt_bg}};
      op_bg   <= nxt_bg;
      op_elem <= elem_of(nxt_state);
      rd_vld  <= !mem_cen && mem_wen[0];
      rd_bg   <= op_bg;
      rd_addr <= mem_a;
      rd_elem <= op_elem;
      if (rd_vld && (mem_q != {DATA_WIDTH{rd_bg}})) begin
        bist_fail <= 1'b1;
        if (!bist_fail) begin
          fail_addr <= rd_addr;
          fail_elem <= rd_elem;
        end
      end
      if (((state == IDLE) || (state == DONE)) && bist_start) begin
        bist_busy <= 1'b1;
        bist_done <= 1'b0;
        bist_fail <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end
      if (state == DRAIN) begin
        bist_busy <= 1'b0;
        bist_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spsram_bist_128x50.sv
// Bench for spsram_bist_128x50: SRAM model with one injectable stuck-at bit, plus a
// list-of-operations March C- reference that predicts every access and the first miscompare.
module tb_spsram_bist_128x50;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        bist_start;
  logic        bist_busy, bist_done, bist_fail;
  logic [6:0]  fail_addr;
  logic [2:0]  fail_elem;
  logic        mem_cen;
  logic [4:0]  mem_wen;
  logic [6:0]  mem_a;
  logic [49:0] mem_d;
  logic [49:0] mem_q = '0;

  int total = 0;
  int bad   = 0;

  bit flt_en;
  int flt_addr, flt_bit;
  bit flt_val;

  logic [49:0] sram [128];

  typedef struct {bit wr; int a; bit bg; int elem;} op_t;
  op_t ops[$];

  always #5 clk = ~clk;

  spsram_bist_128x50 dut (
    .clk(clk), .rst_b(rst_b), .bist_start(bist_start),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  function automatic logic [49:0] faulty(input int a, input logic [49:0] v);
    logic [49:0] r;
    r = v;
    if (flt_en && a == flt_addr) r[flt_bit] = flt_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_cen == 1'b0) begin
      if (mem_wen == 5'h00) sram[mem_a] <= faulty(int'(mem_a), mem_d);
      else                  mem_q <= sram[mem_a];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit wr, input int a, input bit bg, input int e);
    op_t o;
    o.wr = wr; o.a = a; o.bg = bg; o.elem = e;
    ops.push_back(o);
  endtask

  // March C-: element e, direction, then (read bg, write bg) pairs
  task automatic build_ops();
    int a;
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 128; i++) begin
        a = (e == 3 || e == 4) ? 127 - i : i;
        case (e)
          0: push(1, a, 0, e);
          1: begin push(0, a, 0, e); push(1, a, 1, e); end
          2: begin push(0, a, 1, e); push(1, a, 0, e); end
          3: begin push(0, a, 0, e); push(1, a, 1, e); end
          4: begin push(0, a, 1, e); push(1, a, 0, e); end
          default: push(0, a, 0, e);
        endcase
      end
    end
  endtask

  task automatic model(output bit f, output int fa, output int fe);
    logic [49:0] m [128];
    logic [49:0] v;
    f = 0; fa = 0; fe = 0;
    foreach (ops[i]) begin
      v = {50{ops[i].bg}};
      if (ops[i].wr) m[ops[i].a] = faulty(ops[i].a, v);
      else if (m[ops[i].a] !== v && !f) begin
        f = 1; fa = ops[i].a; fe = ops[i].elem;
      end
    end
  endtask

  task automatic run(input string nm, input bit inj);
    bit ef;
    int ea, ee, busy_cnt, wr_cnt, rd_cnt;
    logic [62:0] obs, exp_v;
    model(ef, ea, ee);
    busy_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    @(negedge clk); bist_start = 1'b1;
    @(posedge clk); #1; bist_start = 1'b0;
    chk({nm, "_e0_state"}, {bist_busy, bist_done, bist_fail, fail_addr, fail_elem}, {3'b100, 7'd0, 3'd0});
    for (int k = 0; k < 1280; k++) begin
      if (bist_busy) busy_cnt++;
      if (!mem_cen && mem_wen == 5'h00) wr_cnt++;
      if (!mem_cen && mem_wen == 5'h1f) rd_cnt++;
      obs = {mem_cen, mem_wen, mem_a, (mem_wen == 5'h00) ? mem_d : 50'h0};
      exp_v = ops[k].wr ? {1'b0, 5'h00, 7'(ops[k].a), {50{ops[k].bg}}}
                        : {1'b0, 5'h1f, 7'(ops[k].a), 50'h0};
      chk($sformatf("%s_op%0d", nm, k), obs, exp_v);
      if (k == 640)  chk({nm, "_op640_rd127"}, {mem_wen[0], mem_a}, {1'b1, 7'd127});
      if (k == 1151) chk({nm, "_op1151_wr0"},  {mem_wen[0], mem_a}, {1'b0, 7'd0});
      bist_start = inj && (k == 10 || k == 900);
      @(posedge clk); #1;
    end
    bist_start = 1'b0;
    if (bist_busy) busy_cnt++;
    chk({nm, "_drain"}, {bist_busy, bist_done, mem_cen, mem_wen}, {3'b101, 5'h1f});
    @(posedge clk); #1;
    if (bist_busy) busy_cnt++;
    chk({nm, "_done"}, {bist_busy, bist_done, mem_cen}, 3'b011);
    chk({nm, "_busy_cycles"}, busy_cnt, 1281);
    chk({nm, "_wr_cnt"}, wr_cnt, 640);
    chk({nm, "_rd_cnt"}, rd_cnt, 640);
    chk({nm, "_result"}, {bist_fail, fail_addr, fail_elem}, {ef, 7'(ea), 3'(ee)});
    repeat (3) @(posedge clk); #1;
    chk({nm, "_hold"}, {bist_busy, bist_done, bist_fail, mem_cen}, {2'b01, ef, 1'b1});
  endtask

  initial begin
    build_ops();
    flt_en = 0; flt_addr = 0; flt_bit = 0; flt_val = 0;
    rst_b = 1'b0; bist_start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_state", {bist_busy, bist_done, bist_fail, fail_addr, fail_elem, mem_cen, mem_wen, mem_a, mem_d},
        {3'b000, 7'd0, 3'd0, 1'b1, 5'h1f, 7'd0, 50'h0});
    @(negedge clk); rst_b = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("idle_wait", {bist_busy, bist_done, mem_cen}, 3'b001);

    run("clean", 0);

    flt_en = 1; flt_addr = 5; flt_bit = 17; flt_val = 0;
    run("sa0_b17_a5", 1);
    flt_en = 1; flt_addr = 127; flt_bit = 0; flt_val = 1;
    run("sa1_b0_a127", 0);
    flt_en = 0;
    run("refixed", 1);

    for (int r = 0; r < 4; r++) begin
      flt_en   = ($urandom_range(0, 3) != 0);
      flt_addr = $urandom_range(0, 127);
      flt_bit  = $urandom_range(0, 49);
      flt_val  = 1'($urandom_range(0, 1));
      run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
    end

    flt_en = 0;
    @(negedge clk); bist_start = 1'b1;
    @(posedge clk); #1; bist_start = 1'b0;
    repeat (300) @(posedge clk);
    #3;
    chk("pre_abort_busy", {bist_busy, mem_cen}, 2'b10);
    rst_b = 1'b0;
    #1;
    chk("abort_async", {bist_busy, bist_done, mem_cen, mem_wen, mem_a}, {3'b001, 5'h1f, 7'd0});
    repeat (3) @(posedge clk); #1;
    chk("abort_quiet", {bist_busy, mem_cen}, 2'b01);
    @(negedge clk); rst_b = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("post_abort_idle", {bist_busy, bist_done, mem_cen}, 3'b001);
    run("after_abort", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spsram_bist_128x50.md
SPSRAM_BIST_128X50 -- requirements
Module: spsram_bist_128x50

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 7, address bits; DATA_WIDTH, default 50, word width; WE_WIDTH, default 5, write-enable group count; DEPTH, default 128, words tested.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_b  input  1  asynchronous active-low reset.
REQ-004 bist_start  input  1  start request, sampled in IDLE and DONE only.
REQ-005 bist_busy  output  1  test in progress.
REQ-006 bist_done  output  1  test complete, level, held until next start or reset.
REQ-007 bist_fail  output  1  sticky: at least one read miscompare this run.
REQ-008 fail_addr  output  ADDR_WIDTH  address of the first miscompare.
REQ-009 fail_elem  output  3  march element (0-5) of the first miscompare.
REQ-010 mem_cen  output  1  SRAM chip enable, active low, registered.
REQ-011 mem_wen  output  WE_WIDTH  SRAM write enables, active low, all bits always equal, registered.
REQ-012 mem_a  output  ADDR_WIDTH  SRAM address, registered.
REQ-013 mem_d  output  DATA_WIDTH  SRAM write data, registered.
REQ-014 mem_q  input  DATA_WIDTH  SRAM read data, valid the cycle after a read access.

Function
REQ-015 The block SHALL run March C- in this order: M0 up w0; M1 up (r0,w1); M2 up (r1,w0); M3 down (r0,w1); M4 down (r1,w0); M5 up r0.
REQ-016 Data "0" SHALL be all-zeros and data "1" SHALL be all-ones across DATA_WIDTH.
REQ-017 FSM states SHALL be IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
REQ-018 Each mem operation SHALL take one cycle with no idle cycles between operations or elements.
REQ-019 Two-op elements SHALL do read then write at the same address; the address SHALL step after the write.
REQ-020 "Up" SHALL run addresses 0 to DEPTH-1; "down" SHALL run DEPTH-1 to 0.
REQ-021 Element transitions SHALL occur after the last op at the final address, with no address wrap.
REQ-022 Read op: mem_cen=0, mem_wen all 1. Write op: mem_cen=0, mem_wen all 0, mem_d = background.
REQ-023 No-access cycles: mem_cen=1, mem_wen all 1, mem_a=0, mem_d=0.
REQ-024 The expected value and element of each read SHALL be pipelined one cycle and compared against mem_q on the following edge.
REQ-025 A miscompare SHALL set bist_fail; fail_addr and fail_elem SHALL be captured on the first miscompare only.
REQ-026 Op timing: with bist_start sampled high at edge E0, op k (k=0..1279) SHALL be driven between E(k) and E(k+1).
REQ-027 bist_busy SHALL rise at E0.
REQ-028 After op 1279, the FSM SHALL enter DRAIN for the final compare, then DONE at E1281: bist_busy=0, bist_done=1.
REQ-029 bist_start while busy SHALL be ignored.
REQ-030 bist_start in DONE SHALL restart the test and clear bist_done, bist_fail, fail_addr and fail_elem at E0.
REQ-031 The total access count per run SHALL be 1280: 640 writes and 640 reads.

Reset
REQ-032 rst_b low SHALL immediately force: IDLE; bist_busy=0, bist_done=0, bist_fail=0; fail_addr=0, fail_elem=0; mem_cen=1, mem_wen all 1, mem_a=0, mem_d=0.
REQ-033 Reset asserted mid-test SHALL abort the test with no further SRAM access.
REQ-034 After rst_b deasserts, the block SHALL wait in IDLE for bist_start.

Verification
REQ-035 Fault-free model, start pulse -> busy for exactly 1281 cycles; done=1, fail=0; 1280 cen-low cycles (640 write, 640 read).
REQ-036 Bit 17 stuck-at-0 at address 5 -> fail=1, fail_addr=5, fail_elem=2; test still runs to done.
REQ-037 Bit 0 stuck-at-1 at address 127 -> fail=1, fail_addr=127, fail_elem=1.
REQ-038 Monitor op 640 -> first M3 access is a read at address 127; op 1151 is a write at address 0.
REQ-039 Start pulses at ops 10 and 900 -> both ignored. Start after done with the fault removed -> fail clears at E0 and the run passes.
REQ-040 rst_b low during op 300 -> mem_cen=1 and busy=0 with no clock edge. A new start then completes a full 1281-cycle run with fail=0.
